// File: rtl/decode_pkg.sv
// decode_pkg
// Shared definitions for the RV32I decode stage: major opcodes, the layout of
// the 32-bit control bundle (as a packed struct plus bit offsets), the
// one-hot instruction-format codes, the rd write-back source select codes and
// the decode-stage state enum.
package decode_pkg;

    // Major opcodes (inst[6:0])
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    // funct7 values that are legal on the R-type / shift paths
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    // Control bundle bit offsets and widths (LSB first)
    localparam int CTRL_W          = 32;
    localparam int CTRL_JUMP       = 0;
    localparam int CTRL_JALR       = 1;
    localparam int CTRL_BRANCH     = 2;
    localparam int CTRL_BR_TYPE    = 3;
    localparam int CTRL_BR_TYPE_W  = 3;
    localparam int CTRL_RD_SEL     = 6;
    localparam int CTRL_RD_SEL_W   = 2;
    localparam int CTRL_STORE_SEL  = 8;
    localparam int CTRL_STORE_W    = 3;
    localparam int CTRL_LOAD_SEL   = 11;
    localparam int CTRL_LOAD_W     = 3;
    localparam int CTRL_DMEM_REN   = 14;
    localparam int CTRL_DMEM_WEN   = 15;
    localparam int CTRL_OPSEL      = 16;
    localparam int CTRL_OPSEL_W    = 3;
    localparam int CTRL_ARITH      = 19;
    localparam int CTRL_UNSIGNED   = 20;
    localparam int CTRL_SUB        = 21;
    localparam int CTRL_AUIPC      = 22;
    localparam int CTRL_ALU_SRC    = 23;
    localparam int CTRL_RD_WEN     = 24;
    localparam int CTRL_FORMAT     = 25;
    localparam int CTRL_FORMAT_W   = 6;
    localparam int CTRL_MDU        = 31;

    // One-hot instruction formats
    localparam logic [5:0] FMT_R = 6'b000001;
    localparam logic [5:0] FMT_I = 6'b000010;
    localparam logic [5:0] FMT_S = 6'b000100;
    localparam logic [5:0] FMT_B = 6'b001000;
    localparam logic [5:0] FMT_U = 6'b010000;
    localparam logic [5:0] FMT_J = 6'b100000;

    // rd write-back source
    localparam logic [1:0] RD_SEL_ALU = 2'b00;
    localparam logic [1:0] RD_SEL_IMM = 2'b01;
    localparam logic [1:0] RD_SEL_PC4 = 2'b10;
    localparam logic [1:0] RD_SEL_MEM = 2'b11;

    // Field order is MSB first so the struct packs onto the offsets above.
    typedef struct packed {
        logic       mdu;            // 31
        logic [5:0] format;         // 30:25
        logic       rd_wen;         // 24
        logic       alu_src;        // 23
        logic       auipc;          // 22
        logic       sub;            // 21
        logic       is_unsigned;    // 20
        logic       arith;          // 19
        logic [2:0] opsel;          // 18:16
        logic       dmem_wen;       // 15
        logic       dmem_ren;       // 14
        logic [2:0] load_sel;       // 13:11
        logic [2:0] store_sel;      // 10:8
        logic [1:0] rd_dest_select; // 7:6
        logic [2:0] branch_type;    // 5:3
        logic       branch;         // 2
        logic       jalr;           // 1
        logic       jump;           // 0
    } ctrl_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        HALT  = 2'd2
    } state_t;

endpackage

// File: rtl/decode_comb.sv
// decode_comb
// Purely combinational RV32I (optional M) instruction decoder.
// Ports:
//   i_inst    in  32  instruction word
//   o_ctrl    out 32  packed control bundle (decode_pkg::ctrl_t layout)
//   o_illegal out 1   instruction is not a legal encoding
//   o_system  out 1   instruction is ECALL/EBREAK (SYSTEM opcode)
// An illegal instruction always produces an all-zero bundle and o_system=0.
module decode_comb
    import decode_pkg::*;
#(
    parameter int EN_MEXT = 0
) (
    input  logic [31:0] i_inst,
    output logic [31:0] o_ctrl,
    output logic        o_illegal,
    output logic        o_system
);

    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic [6:0] w_funct7;
    ctrl_t      w_ctrl;
    logic       w_illegal;
    logic       w_system;
    logic       w_unused_fields;

    assign w_opcode = i_inst[6:0];
    assign w_funct3 = i_inst[14:12];
    assign w_funct7 = i_inst[31:25];

    // Register specifiers are consumed by the register file, not by decode.
    assign w_unused_fields = ^{i_inst[24:15], i_inst[11:7]};

    always_comb begin
        w_ctrl    = '0;
        w_illegal = 1'b0;
        w_system  = 1'b0;

        case (w_opcode)
            OPC_OP: begin
                w_ctrl.format      = FMT_R;
                w_ctrl.rd_wen      = 1'b1;
                w_ctrl.opsel       = w_funct3;
                w_ctrl.is_unsigned = (w_funct3 == 3'b011);
                w_ctrl.arith       = (w_funct3 == 3'b101) && w_funct7[5];
                w_ctrl.sub         = (w_funct3 == 3'b000) && w_funct7[5];
                if (w_funct7 == F7_BASE) begin
                    w_illegal = 1'b0;
                end else if (w_funct7 == F7_ALT) begin
                    // Only ADD/SUB and SRL/SRA have an alternate encoding.
                    w_illegal = !((w_funct3 == 3'b000) || (w_funct3 == 3'b101));
                end else if ((w_funct7 == F7_MULDIV) && (EN_MEXT != 0)) begin
                    w_ctrl.mdu = 1'b1;
                end else begin
                    w_illegal = 1'b1;
                end
            end

            OPC_OP_IMM: begin
                w_ctrl.format      = FMT_I;
                w_ctrl.rd_wen      = 1'b1;
                w_ctrl.alu_src     = 1'b1;
                w_ctrl.opsel       = w_funct3;
                w_ctrl.is_unsigned = (w_funct3 == 3'b011);
                w_ctrl.arith       = (w_funct3 == 3'b101) && w_funct7[5];
                // funct7 is only an opcode extension for the shift-immediates;
                // for the others those bits are part of the immediate.
                if (w_funct3 == 3'b001) begin
                    w_illegal = (w_funct7 != F7_BASE);
                end else if (w_funct3 == 3'b101) begin
                    w_illegal = (w_funct7 != F7_BASE) && (w_funct7 != F7_ALT);
                end
            end

            OPC_LUI: begin
                w_ctrl.format         = FMT_U;
                w_ctrl.rd_wen         = 1'b1;
                w_ctrl.rd_dest_select = RD_SEL_IMM;
            end

            OPC_AUIPC: begin
                w_ctrl.format  = FMT_U;
                w_ctrl.rd_wen  = 1'b1;
                w_ctrl.auipc   = 1'b1;
                w_ctrl.alu_src = 1'b1;
            end

            OPC_LOAD: begin
                w_ctrl.format         = FMT_I;
                w_ctrl.rd_wen         = 1'b1;
                w_ctrl.alu_src        = 1'b1;
                w_ctrl.dmem_ren       = 1'b1;
                w_ctrl.load_sel       = w_funct3;
                w_ctrl.rd_dest_select = RD_SEL_MEM;
                w_illegal = (w_funct3 == 3'b011) || (w_funct3 == 3'b110) ||
                            (w_funct3 == 3'b111);
            end

            OPC_STORE: begin
                w_ctrl.format    = FMT_S;
                w_ctrl.alu_src   = 1'b1;
                w_ctrl.dmem_wen  = 1'b1;
                w_ctrl.store_sel = w_funct3;
                w_illegal = (w_funct3 > 3'b010);
            end

            OPC_BRANCH: begin
                w_ctrl.format      = FMT_B;
                w_ctrl.branch      = 1'b1;
                w_ctrl.branch_type = w_funct3;
                w_ctrl.is_unsigned = w_funct3[1];
                w_illegal = (w_funct3 == 3'b010) || (w_funct3 == 3'b011);
            end

            OPC_JAL: begin
                w_ctrl.format         = FMT_J;
                w_ctrl.jump           = 1'b1;
                w_ctrl.rd_wen         = 1'b1;
                w_ctrl.rd_dest_select = RD_SEL_PC4;
            end

            OPC_JALR: begin
                w_ctrl.format         = FMT_I;
                w_ctrl.jalr           = 1'b1;
                w_ctrl.rd_wen         = 1'b1;
                w_ctrl.alu_src        = 1'b1;
                w_ctrl.rd_dest_select = RD_SEL_PC4;
                w_illegal = (w_funct3 != 3'b000);
            end

            // FENCE is a legal no-op on this single-hart in-order pipeline.
            OPC_MISC_MEM: begin
                w_ctrl = '0;
            end

            OPC_SYSTEM: begin
                w_system = 1'b1;
            end

            default: begin
                w_illegal = 1'b1;
            end
        endcase

        if (w_illegal) begin
            w_ctrl   = '0;
            w_system = 1'b0;
        end
    end

    assign o_ctrl    = w_ctrl;
    assign o_illegal = w_illegal;
    assign o_system  = w_system;

endmodule

// File: rtl/decode_stage.sv
// decode_stage
// Registered decode stage between fetch and execute. The incoming instruction
// is decoded combinationally and captured, together with its PC, in a
// single-entry register guarded by a valid/ready handshake.
// Ports:
//   i_clk, i_rst          clock (rising edge), synchronous active-high reset
//   i_flush               drop the held entry and any same-cycle input
//   i_valid/o_ready       upstream handshake; i_inst, i_pc are the payload
//   o_valid/i_ready       downstream handshake; o_inst, o_pc, o_ctrl payload
//   o_illegal, o_system   flags for the held instruction
//   o_halted              stage stopped after handing on SYSTEM/illegal
//   o_dec_count           saturating count of instructions handed downstream
module decode_stage
    import decode_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int EN_MEXT = 0,
    parameter int CNT_W   = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_flush,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [31:0]      i_inst,
    input  logic [XLEN-1:0]  i_pc,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [31:0]      o_inst,
    output logic [XLEN-1:0]  o_pc,
    output logic [31:0]      o_ctrl,
    output logic             o_illegal,
    output logic             o_system,
    output logic             o_halted,
    output logic [CNT_W-1:0] o_dec_count
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        if (&value) begin
            return value;
        end
        return value + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    logic [31:0]      w_dec_ctrl;
    logic             w_dec_illegal;
    logic             w_dec_system;
    logic             w_valid;
    logic             w_halted;
    logic             w_stop_held;
    logic             w_ready;
    logic             w_xfer;
    logic             w_load;

    state_t           r_state;
    logic [31:0]      r_inst_p1;
    logic [XLEN-1:0]  r_pc_p1;
    logic [31:0]      r_ctrl_p1;
    logic             r_illegal_p1;
    logic             r_system_p1;
    logic [CNT_W-1:0] r_count;

    decode_comb #(
        .EN_MEXT (EN_MEXT)
    ) u_decode (
        .i_inst    (i_inst),
        .o_ctrl    (w_dec_ctrl),
        .o_illegal (w_dec_illegal),
        .o_system  (w_dec_system)
    );

    assign w_valid     = (r_state == FULL);
    assign w_halted    = (r_state == HALT);
    // A held SYSTEM/illegal entry is the last one before HALT, so nothing may
    // queue behind it.
    assign w_stop_held = r_illegal_p1 | r_system_p1;
    assign w_ready     = (r_state == EMPTY) || (w_valid && i_ready && !w_stop_held);
    assign w_xfer      = w_valid && i_ready;
    assign w_load      = i_valid && w_ready && !i_flush;

    // ---- stage boundary: decode -> execute register ----
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= EMPTY;
            r_inst_p1    <= '0;
            r_pc_p1      <= '0;
            r_ctrl_p1    <= '0;
            r_illegal_p1 <= 1'b0;
            r_system_p1  <= 1'b0;
            r_count      <= '0;
        end else begin
            // A transfer is counted even when a flush discards the state update.
            if (w_xfer) begin
                r_count <= sat_inc(r_count);
            end

            if (w_load) begin
                r_inst_p1    <= i_inst;
                r_pc_p1      <= i_pc;
                r_ctrl_p1    <= w_dec_ctrl;
                r_illegal_p1 <= w_dec_illegal;
                r_system_p1  <= w_dec_system;
            end else if (w_xfer || i_flush) begin
                // Flags describe the held entry only; clear them once it leaves.
                r_illegal_p1 <= 1'b0;
                r_system_p1  <= 1'b0;
            end

            case (r_state)
                EMPTY: begin
                    if (w_load) begin
                        r_state <= FULL;
                    end
                end
                FULL: begin
                    if (i_flush) begin
                        r_state <= EMPTY;
                    end else if (w_xfer && w_stop_held) begin
                        r_state <= HALT;
                    end else if (w_xfer && !w_load) begin
                        r_state <= EMPTY;
                    end
                end
                HALT: begin
                    r_state <= HALT;
                end
                default: begin
                    r_state <= EMPTY;
                end
            endcase
        end
    end

    assign o_ready     = w_ready;
    assign o_valid     = w_valid;
    assign o_halted    = w_halted;
    assign o_inst      = r_inst_p1;
    assign o_pc        = r_pc_p1;
    assign o_ctrl      = r_ctrl_p1;
    assign o_illegal   = r_illegal_p1;
    assign o_system    = r_system_p1;
    assign o_dec_count = r_count;

endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;

    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    localparam logic [31:0] I_ADD    = 32'h002081B3;
    localparam logic [31:0] I_SUB    = 32'h402081B3;
    localparam logic [31:0] I_LW     = 32'h0000A183;
    localparam logic [31:0] I_MUL    = 32'h022081B3;
    localparam logic [31:0] I_EBREAK = 32'h00100073;
    localparam logic [31:0] I_ECALL  = 32'h00000073;
    localparam logic [31:0] I_BAD    = 32'hFFFFFFFF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_inst;
    logic [31:0] in_pc;
    logic        dn_ready;

    logic          d0_ready, d0_valid, d0_illegal, d0_system, d0_halted;
    logic [31:0]   d0_inst, d0_pc, d0_ctrl;
    logic [CW-1:0] d0_count;

    logic          d1_ready, d1_valid, d1_illegal, d1_system, d1_halted;
    logic [31:0]   d1_inst, d1_pc, d1_ctrl;
    logic [CW-1:0] d1_count;
    logic          unused_d1;

    assign unused_d1 = ^{d1_ready, d1_valid, d1_system, d1_inst, d1_pc, d1_count};

    decode_stage #(.XLEN(32), .EN_MEXT(0), .CNT_W(CW)) dut0 (
        .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_valid(in_valid),
        .o_ready(d0_ready), .i_inst(in_inst), .i_pc(in_pc), .o_valid(d0_valid),
        .i_ready(dn_ready), .o_inst(d0_inst), .o_pc(d0_pc), .o_ctrl(d0_ctrl),
        .o_illegal(d0_illegal), .o_system(d0_system), .o_halted(d0_halted),
        .o_dec_count(d0_count)
    );

    decode_stage #(.XLEN(32), .EN_MEXT(1), .CNT_W(CW)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_valid(in_valid),
        .o_ready(d1_ready), .i_inst(in_inst), .i_pc(in_pc), .o_valid(d1_valid),
        .i_ready(dn_ready), .o_inst(d1_inst), .o_pc(d1_pc), .o_ctrl(d1_ctrl),
        .o_illegal(d1_illegal), .o_system(d1_system), .o_halted(d1_halted),
        .o_dec_count(d1_count)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference decoder: {illegal, system, ctrl} straight from the RV32I rules,
    // with bit positions written out as numbers.
    function automatic logic [33:0] ref_decode(input logic [31:0] ins, input bit mext);
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] c;
        bit          ill;
        bit          sys;
        op = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
        c = '0; ill = 0; sys = 0;
        case (op)
            7'h33: begin
                c[25] = 1; c[24] = 1; c[18:16] = f3; c[20] = (f3 == 3'd3);
                if (f7 == 7'h20) begin
                    ill = !(f3 == 3'd0 || f3 == 3'd5);
                    c[21] = (f3 == 3'd0); c[19] = (f3 == 3'd5);
                end else if (f7 == 7'h01) begin
                    ill = !mext; c[31] = 1;
                end else begin
                    ill = (f7 != 7'h00);
                end
            end
            7'h13: begin
                c[26] = 1; c[24] = 1; c[23] = 1; c[18:16] = f3; c[20] = (f3 == 3'd3);
                if (f3 == 3'd1) ill = (f7 != 7'h00);
                if (f3 == 3'd5) begin
                    if (f7 == 7'h20) c[19] = 1;
                    else ill = (f7 != 7'h00);
                end
            end
            7'h37: begin c[29] = 1; c[24] = 1; c[7:6] = 2'b01; end
            7'h17: begin c[29] = 1; c[24] = 1; c[22] = 1; c[23] = 1; end
            7'h03: begin
                c[26] = 1; c[24] = 1; c[23] = 1; c[14] = 1; c[13:11] = f3; c[7:6] = 2'b11;
                ill = (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
            end
            7'h23: begin c[27] = 1; c[23] = 1; c[15] = 1; c[10:8] = f3; ill = (f3 > 3'd2); end
            7'h63: begin
                c[28] = 1; c[2] = 1; c[5:3] = f3; c[20] = f3[1];
                ill = (f3 == 3'd2 || f3 == 3'd3);
            end
            7'h6F: begin c[30] = 1; c[0] = 1; c[24] = 1; c[7:6] = 2'b10; end
            7'h67: begin
                c[26] = 1; c[1] = 1; c[24] = 1; c[23] = 1; c[7:6] = 2'b10;
                ill = (f3 != 3'd0);
            end
            7'h0F: begin c = '0; end
            7'h73: begin sys = 1; end
            default: begin ill = 1; end
        endcase
        if (ill) begin c = '0; sys = 0; end
        return {ill, sys, c};
    endfunction

    // Behavioural model of the stage: one slot, a halted flag and a counter.
    bit          m_live   = 0;
    bit          m_valid  = 0;
    bit          m_halted = 0;
    logic [31:0] m_inst   = '0;
    logic [31:0] m_pc     = '0;
    int          m_count  = 0;
    logic [33:0] m_dec;
    logic        m_stop, m_ready, m_xfer, m_acc;

    assign m_dec   = ref_decode(m_inst, 1'b0);
    assign m_stop  = m_dec[33] | m_dec[32];
    assign m_ready = m_live && !m_halted && (!m_valid || (dn_ready && !m_stop));
    assign m_xfer  = m_valid && dn_ready;
    assign m_acc   = in_valid && m_ready;

    always @(posedge clk) begin
        if (rst) begin
            m_live   <= 1;
            m_valid  <= 0;
            m_halted <= 0;
            m_count  <= 0;
            m_inst   <= '0;
            m_pc     <= '0;
        end else if (m_live && !m_halted) begin
            if (m_xfer) m_count <= (m_count == CMAX) ? CMAX : m_count + 1;
            if (flush) begin
                m_valid <= 0;
            end else if (m_xfer && m_stop) begin
                m_valid  <= 0;
                m_halted <= 1;
            end else if (m_acc) begin
                m_valid <= 1;
                m_inst  <= in_inst;
                m_pc    <= in_pc;
            end else if (m_xfer) begin
                m_valid <= 0;
            end
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            check("valid", 64'(d0_valid), 64'(m_valid));
            check("halted", 64'(d0_halted), 64'(m_halted));
            check("ready", 64'(d0_ready), 64'(m_ready));
            check("count", 64'(d0_count), 64'(m_count));
            if (m_valid) begin
                check("inst", 64'(d0_inst), 64'(m_inst));
                check("pc", 64'(d0_pc), 64'(m_pc));
                check("ctrl", 64'(d0_ctrl), 64'(m_dec[31:0]));
                check("illegal", 64'(d0_illegal), 64'(m_dec[33]));
                check("system", 64'(d0_system), 64'(m_dec[32]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                         input logic rdy, input logic fl);
        in_valid = v; in_inst = ins; in_pc = pc; dn_ready = rdy; flush = fl;
    endtask

    logic [31:0] prog [0:14];
    logic [31:0] pc_n;
    bit          got;

    initial begin
        prog = '{32'h00500093, 32'h00209093, 32'h4030D113, 32'h0010B193, 32'h123452B7,
                 32'h00001317, 32'h0020A423, 32'h0020E463, 32'h010000EF, 32'h00008067,
                 32'h4020D233, 32'h0020B2B3, 32'h0000C383, 32'h00208023, 32'h0020D463};
        got = 0;
        rst = 1;
        drive(0, '0, '0, 0, 0);
        tick();
        tick();
        rst = 0;

        // Reset values
        check("rst_valid", 64'(d0_valid), 64'd0);
        check("rst_halted", 64'(d0_halted), 64'd0);
        check("rst_count", 64'(d0_count), 64'd0);
        check("rst_ctrl", 64'(d0_ctrl), 64'd0);
        check("rst_inst", 64'(d0_inst), 64'd0);
        check("rst_pc", 64'(d0_pc), 64'd0);
        check("rst_illegal", 64'(d0_illegal), 64'd0);
        check("rst_system", 64'(d0_system), 64'd0);
        check("rst_ready", 64'(d0_ready), 64'd1);

        // ADD x3,x1,x2
        drive(1, I_ADD, 32'h100, 1, 0);
        tick();
        check("add_valid", 64'(d0_valid), 64'd1);
        check("add_ctrl", 64'(d0_ctrl), 64'h03000000);
        check("add_format", 64'(d0_ctrl[30:25]), 64'b000001);
        drive(0, '0, '0, 1, 0);
        tick();
        check("add_count", 64'(d0_count), 64'd1);

        // SUB held for 3 cycles with LW waiting, then LW follows
        drive(1, I_SUB, 32'h104, 0, 0);
        tick();
        drive(1, I_LW, 32'h108, 0, 0);
        for (int i = 0; i < 3; i++) begin
            check("stall_ready", 64'(d0_ready), 64'd0);
            check("stall_ctrl", 64'(d0_ctrl), 64'h03200000);
            tick();
        end
        dn_ready = 1;
        tick();
        check("lw_inst", 64'(d0_inst), 64'(I_LW));
        check("lw_load_sel", 64'(d0_ctrl[13:11]), 64'b010);
        check("lw_dmem_ren", 64'(d0_ctrl[14]), 64'd1);
        check("lw_rd_sel", 64'(d0_ctrl[7:6]), 64'b11);
        drive(0, '0, '0, 1, 0);
        tick();
        check("lw_count", 64'(d0_count), 64'd3);

        // EBREAK held, flushed together with a same-cycle input
        drive(1, I_EBREAK, 32'h200, 0, 0);
        tick();
        check("ebreak_system", 64'(d0_system), 64'd1);
        check("ebreak_ctrl", 64'(d0_ctrl), 64'd0);
        check("ebreak_ready", 64'(d0_ready), 64'd0);
        drive(1, I_ADD, 32'h204, 0, 1);
        tick();
        check("flush_valid", 64'(d0_valid), 64'd0);
        check("flush_halted", 64'(d0_halted), 64'd0);
        check("flush_count", 64'(d0_count), 64'd3);
        // Flush from EMPTY drops an acceptable input
        drive(1, I_ADD, 32'h208, 0, 1);
        tick();
        check("flush_empty_valid", 64'(d0_valid), 64'd0);
        // ECALL flushed while transferring: counted, no halt
        drive(1, I_ECALL, 32'h300, 0, 0);
        tick();
        drive(0, '0, '0, 1, 1);
        tick();
        check("flush_xfer_count", 64'(d0_count), 64'd4);
        check("flush_xfer_halted", 64'(d0_halted), 64'd0);
        drive(0, '0, '0, 0, 0);
        tick();

        // Mixed legal stream with a varying downstream ready
        pc_n = 32'h1000;
        for (int k = 0; k < 15; k++) begin
            got = 0;
            for (int j = 0; j < 10 && !got; j++) begin
                drive(1, prog[k], pc_n, ((k + j) % 3) != 2, 0);
                #1;
                got = d0_ready;
                tick();
            end
            if (!got) check("accept_timeout", 64'(got), 64'd1);
            pc_n = pc_n + 32'd4;
        end
        drive(0, '0, '0, 1, 0);
        tick();
        tick();

        // Back-to-back ADDs push the counter into saturation
        for (int k = 0; k < 20; k++) begin
            drive(1, I_ADD, pc_n, 1, 0);
            tick();
            pc_n = pc_n + 32'd4;
        end
        drive(0, '0, '0, 1, 0);
        tick();
        check("sat_count", 64'(d0_count), 64'(CMAX));

        // MUL: illegal without M, MDU op with M
        drive(1, I_MUL, 32'h400, 0, 0);
        tick();
        check("mul_ill_d0", 64'(d0_illegal), 64'd1);
        check("mul_ctrl_d0", 64'(d0_ctrl), 64'd0);
        check("mul_ill_d1", 64'(d1_illegal), 64'd0);
        check("mul_mdu_d1", 64'(d1_ctrl[31]), 64'd1);
        check("mul_opsel_d1", 64'(d1_ctrl[18:16]), 64'b000);
        drive(0, '0, '0, 1, 0);
        tick();
        check("mul_halt_d0", 64'(d0_halted), 64'd1);
        check("mul_nohalt_d1", 64'(d1_halted), 64'd0);
        // Flush in HALT has no effect
        drive(1, I_ADD, 32'h500, 1, 1);
        tick();
        drive(1, I_ADD, 32'h504, 1, 0);
        tick();
        check("halt_flush_halted", 64'(d0_halted), 64'd1);
        check("halt_flush_ready", 64'(d0_ready), 64'd0);

        // Reset leaves HALT; then an all-ones word halts the stage
        rst = 1;
        drive(0, '0, '0, 0, 0);
        tick();
        rst = 0;
        check("rst2_halted", 64'(d0_halted), 64'd0);
        check("rst2_count", 64'(d0_count), 64'd0);
        drive(1, I_BAD, 32'h600, 0, 0);
        tick();
        check("bad_illegal", 64'(d0_illegal), 64'd1);
        check("bad_ctrl", 64'(d0_ctrl), 64'd0);
        drive(1, I_ADD, 32'h604, 1, 0);
        tick();
        check("bad_halted", 64'(d0_halted), 64'd1);
        check("bad_ready", 64'(d0_ready), 64'd0);
        check("bad_count", 64'(d0_count), 64'd1);
        repeat (3) tick();
        check("bad_held_halted", 64'(d0_halted), 64'd1);

        rst = 1;
        tick();
        rst = 0;

        // Reset in the middle of a stream
        for (int k = 0; k < 4; k++) begin
            drive(1, I_ADD, 32'h700 + 32'(k * 4), 1, 0);
            tick();
        end
        check("mid_count_pre", 64'(d0_count), 64'd3);
        rst = 1;
        tick();
        check("mid_valid", 64'(d0_valid), 64'd0);
        check("mid_count", 64'(d0_count), 64'd0);
        check("mid_ctrl", 64'(d0_ctrl), 64'd0);
        check("mid_inst", 64'(d0_inst), 64'd0);
        check("mid_pc", 64'(d0_pc), 64'd0);
        check("mid_halted", 64'(d0_halted), 64'd0);
        rst = 0;
        drive(0, '0, '0, 1, 0);
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
